mtm_alu_deserializer: RTL

- Upstream stage of the ALU datapath. Receives the serial input line one bit per clk and reassembles a transaction of 8 data packets plus 1 command packet.
- Checks framing, packet count, CRC and opcode.
- Presents operands A/B, the opcode and one-hot error flags to the ALU core with a single-cycle valid strobe. The core's result feeds the output serializer.

---
 rtl/mtm_alu_deserializer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: reassembles 8 data packets + 1 command packet from the serial line, checks them, strobes operands to the ALU core
// Ports: clk, rst_n (sync, active-low); sin serial input (idle 1);
//        a/b operands, op opcode, out_valid one-cycle strobe, err_data/err_crc/err_op one-hot error flags.
// Build option: define MTM_DESER_CRC_CHECK_EN to enable CRC-4 checking (err_crc is tied 0 otherwise).
module mtm_alu_deserializer #(
  parameter int DATA_PKTS = 8,
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sin,
  output logic [31:0]     a,
  output logic [31:0]     b,
  output logic [OP_W-1:0] op,
  output logic            out_valid,
  output logic            err_data,
  output logic            err_crc,
  output logic            err_op
);
  localparam int CW = $clog2(DATA_PKTS + 2);
  typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, STOP, CHECK, WAIT_HIGH} state_t;
  state_t          state_q, state_d;
  logic            type_q, type_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic [63:0]     data_q, data_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            valid_q, valid_d, ed_q, ed_d, ec_q, ec_d, eo_q, eo_d, ferr_q, ferr_d;
  logic [OP_W-1:0] rx_op;
  logic            crc_bad, op_bad, cnt_bad;
  assign rx_op   = byte_q[OP_W+3:4];
  assign op_bad  = !(rx_op == OP_W'(0) || rx_op == OP_W'(1) || rx_op == OP_W'(4) || rx_op == OP_W'(5));
  assign cnt_bad = pkt_cnt_q != CW'(DATA_PKTS);
`ifdef MTM_DESER_CRC_CHECK_EN
  function automatic logic [3:0] crc4(input logic [64+OP_W:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 64 + OP_W; i >= 0; i--) c = {c[2:0], 1'b0} ^ ((m[i] ^ c[3]) ? 4'h3 : 4'h0);
    return c;
  endfunction
  // Evaluated while the cmd stop bit is on the line so the flag is registered into CHECK.
  assign crc_bad = crc4({data_q, 1'b1, rx_op}) != byte_q[3:0];
`else
  assign crc_bad = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    bit_cnt_d = bit_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    byte_d    = byte_q;
    data_d    = data_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    ed_d      = ed_q;
    ec_d      = ec_q;
    eo_d      = eo_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE:      state_d = sin ? IDLE : TYPE;
      TYPE: begin
        type_d    = sin;
        bit_cnt_d = '0;
        state_d   = PAYLOAD;
      end
      PAYLOAD: begin
        byte_d    = {byte_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        state_d   = bit_cnt_q == 3'd7 ? STOP : PAYLOAD;
      end
      STOP:
        if (sin && !type_q) begin
          data_d    = {data_q[55:0], byte_q};
          pkt_cnt_d = pkt_cnt_q == CW'(DATA_PKTS + 1) ? pkt_cnt_q : pkt_cnt_q + 1'b1;
          state_d   = IDLE;
        end else begin
          // Outputs are registered here so they are valid alongside out_valid during CHECK.
          ferr_d  = !sin;
          valid_d = 1'b1;
          a_d     = data_q[31:0];
          b_d     = data_q[63:32];
          op_d    = rx_op;
          ed_d    = !sin || cnt_bad;
          ec_d    = !ed_d && crc_bad;
          eo_d    = !ed_d && !crc_bad && op_bad;
          state_d = CHECK;
        end
      CHECK: begin
        pkt_cnt_d = '0;
        state_d   = ferr_q ? WAIT_HIGH : IDLE;
      end
      WAIT_HIGH: state_d = sin ? IDLE : WAIT_HIGH;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q   <= IDLE;
      type_q    <= 1'b0;
      bit_cnt_q <= '0;
      pkt_cnt_q <= '0;
      byte_q    <= '0;
      data_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      valid_q   <= 1'b0;
      ed_q      <= 1'b0;
      ec_q      <= 1'b0;
      eo_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      bit_cnt_q <= bit_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      byte_q    <= byte_d;
      data_q    <= data_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      ed_q      <= ed_d;
      ec_q      <= ec_d;
      eo_q      <= eo_d;
      ferr_q    <= ferr_d;
    end
  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign out_valid = valid_q;
  assign err_data  = ed_q;
  assign err_crc   = ec_q;
  assign err_op    = eo_q;
endmodule
